product_accumulator: RTL and testbench

Downstream companion to the pipelined inferred multiplier. It tracks a valid/last tag alongside each operand pair issued into the fixed-latency multiplier and sums the aligned products into one unsigned accumulator per vector. Completed sums are queued in a small result FIFO and presented on a valid/ready port. It also exerts issue backpressure, because the multiplier pipeline itself cannot stall.

---
 rtl/product_accumulator.sv | 153 +++++++++++++++
 tb/tb_product_accumulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Tags each issue into a fixed-latency multiplier, sums aligned products per vector and queues the sums
// in a credit-protected result FIFO. Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN clamps overflowing sums.
module product_accumulator #(
   parameter int PRODUCT_WIDTH   = 32,
   parameter int ACC_WIDTH       = 48,
   parameter int PIPELINE_STAGES = 7,
   parameter int RESULT_DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic                     issue_last,
   output logic                     issue_ready,
   input  logic [PRODUCT_WIDTH-1:0] product,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_WIDTH-1:0]     out_data,
   output logic                     out_overflow,
   output logic                     busy
);
   localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

   logic [PIPELINE_STAGES-1:0] r_tag_valid;
   logic [PIPELINE_STAGES-1:0] r_tag_last;
   logic                       w_accept;
   logic                       w_al_valid;
   logic                       w_al_last;

   logic [ACC_WIDTH-1:0]       r_acc;
   logic                       r_acc_ovf;
   logic                       r_first;
   logic [ACC_WIDTH:0]         w_raw_sum;
   logic [ACC_WIDTH-1:0]       w_sum;
   logic                       w_ovf;

   logic [ACC_WIDTH-1:0]       r_fifo_data [RESULT_DEPTH];
   logic                       r_fifo_ovf  [RESULT_DEPTH];
   logic [PTR_W-1:0]           r_wr_ptr;
   logic [PTR_W-1:0]           r_rd_ptr;
   logic [CNT_W-1:0]           r_count;
   logic [CNT_W-1:0]           r_lasts;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_last_in;
   logic [CNT_W:0]             w_credit_used;

   function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RESULT_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign w_accept   = issue_valid && issue_ready;
   assign w_last_in  = w_accept && issue_last;
   assign w_al_valid = r_tag_valid[PIPELINE_STAGES-1];
   assign w_al_last  = w_al_valid && r_tag_last[PIPELINE_STAGES-1];

   // Tag line mirrors the multiplier pipeline; the last stage lines up with product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_valid <= '0;
         r_tag_last  <= '0;
      end else begin
         for (int i = PIPELINE_STAGES - 1; i > 0; i--) begin
            r_tag_valid[i] <= r_tag_valid[i-1];
            r_tag_last[i]  <= r_tag_last[i-1];
         end
         r_tag_valid[0] <= w_accept;
         r_tag_last[0]  <= w_last_in;
      end
   end

   assign w_raw_sum = {1'b0, (r_first ? {ACC_WIDTH{1'b0}} : r_acc)} + (ACC_WIDTH+1)'(product);
   assign w_ovf     = w_raw_sum[ACC_WIDTH] | (r_acc_ovf & ~r_first);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   // Sticky overflow keeps every later partial sum of the vector pinned at full scale.
   assign w_sum = w_ovf ? {ACC_WIDTH{1'b1}} : w_raw_sum[ACC_WIDTH-1:0];
`else
   assign w_sum = w_raw_sum[ACC_WIDTH-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_acc_ovf <= 1'b0;
         r_first   <= 1'b1;
      end else if (w_al_valid) begin
         if (w_al_last) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
            r_first   <= 1'b1;
         end else begin
            r_acc     <= w_sum;
            r_acc_ovf <= w_ovf;
            r_first   <= 1'b0;
         end
      end
   end

   assign w_push = w_al_last;
   assign w_pop  = out_valid && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RESULT_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_ovf[i]  <= 1'b0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_sum;
            r_fifo_ovf[r_wr_ptr]  <= w_ovf;
            r_wr_ptr              <= f_next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next_ptr(r_rd_ptr);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_lasts <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         case ({w_last_in, w_al_last})
            2'b10:   r_lasts <= r_lasts + CNT_W'(1);
            2'b01:   r_lasts <= r_lasts - CNT_W'(1);
            default: r_lasts <= r_lasts;
         endcase
      end
   end

   // Each in-flight last owns a reserved FIFO slot, so a push can never find the FIFO full.
   assign w_credit_used = (CNT_W+1)'(r_lasts) + (CNT_W+1)'(r_count);
   assign issue_ready   = w_credit_used < (CNT_W+1)'(RESULT_DEPTH);

   assign out_valid    = (r_count != '0);
   assign out_data     = r_fifo_data[r_rd_ptr];
   assign out_overflow = r_fifo_ovf[r_rd_ptr];
   assign busy         = (|r_tag_valid) | ~r_first | out_valid;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator: a vector-level model predicts sums, overflow,
// credit and result timing, and every cycle's outputs are compared against it.
module tb_product_accumulator;
   localparam int PW   = 32;
   localparam int AW   = 34;
   localparam int S    = 7;
   localparam int D    = 2;
   localparam int HIST = 8192;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          issue_valid = 1'b0;
   logic          issue_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [PW-1:0] product = '0;
   logic          issue_ready;
   logic          out_valid;
   logic [AW-1:0] out_data;
   logic          out_overflow;
   logic          busy;

   product_accumulator #(
      .PRODUCT_WIDTH(PW), .ACC_WIDTH(AW), .PIPELINE_STAGES(S), .RESULT_DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_last(issue_last), .issue_ready(issue_ready),
      .product(product),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_overflow(out_overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] data;
      bit            ovf;
      int            vis;
   } res_t;

   res_t          exp_q[$];
   res_t          popped_q[$];
   logic [63:0]   cur_sum = '0;
   int            cur_len = 0;
   logic [PW-1:0] prod_hist [HIST];
   bit            acc_hist  [HIST];
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;
   int            n_chk = 0;
   int            first_valid_cyc = -1;
   int            rdy_mode = 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Whole-vector arithmetic: overflow means the true sum does not fit in AW bits.
   function automatic res_t f_result(input logic [63:0] total, input int vis);
      res_t        r;
      logic [63:0] lim;
      lim   = 64'd1 << AW;
      r.ovf = (total >= lim);
      r.vis = vis;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      r.data = r.ovf ? {AW{1'b1}} : total[AW-1:0];
`else
      r.data = total[AW-1:0];
`endif
      return r;
   endfunction

   task automatic step(input bit v, input bit l, input logic [PW-1:0] val, output bit accepted);
      bit exp_valid;
      bit exp_ready;
      bit rdy;
      @(negedge clk);
      exp_valid = (exp_q.size() != 0) && (exp_q[0].vis <= cyc);
      exp_ready = (exp_q.size() < D);
      check("out_valid", out_valid, exp_valid);
      check("issue_ready", issue_ready, exp_ready);
      check("busy", busy, (exp_q.size() != 0) || (cur_len != 0));
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_valid) begin
         check("out_data", out_data, exp_q[0].data);
         check("out_overflow", out_overflow, exp_q[0].ovf);
      end
      case (rdy_mode)
         0:       rdy = 1'b0;
         1:       rdy = 1'b1;
         2:       rdy = cyc[0];
         default: rdy = ($urandom_range(0, 9) < 6);
      endcase
      issue_valid = v;
      issue_last  = l;
      out_ready   = rdy;
      product     = (cyc >= S && acc_hist[cyc-S]) ? prod_hist[cyc-S] : $urandom;
      accepted       = v && exp_ready;
      acc_hist[cyc]  = accepted;
      prod_hist[cyc] = val;
      if (exp_valid && rdy) begin
         popped_q.push_back(exp_q[0]);
         void'(exp_q.pop_front());
      end
      if (accepted) begin
         cur_sum = cur_sum + 64'(val);
         cur_len++;
         if (l) begin
            exp_q.push_back(f_result(cur_sum, cyc + S + 1));
            cur_sum = '0;
            cur_len = 0;
         end
      end
      $display("cyc %0d: iv=%0d il=%0d val=%0h acc=%0d ordy=%0d ov=%0d od=%0h", cyc, v, l, val,
               accepted, rdy, out_valid, out_data);
      cyc++;
      n_vec++;
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) step(1'b0, 1'b0, $urandom, a);
   endtask

   task automatic issue_until(input logic [PW-1:0] val, input bit l);
      bit a;
      int tries;
      tries = 0;
      do begin
         step(1'b1, l, val, a);
         tries++;
      end while (!a && tries < 60);
      if (!a) begin
         n_err++;
         $display("FAIL issue_timeout: got not-accepted, required accepted within 60 cycles");
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " issue_ready"}, issue_ready, 1'b1);
      check({tag, " out_valid"}, out_valid, 1'b0);
      check({tag, " out_data"}, out_data, '0);
      check({tag, " out_overflow"}, out_overflow, 1'b0);
      check({tag, " busy"}, busy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      issue_valid = 1'b0;
      issue_last  = 1'b0;
      product     = $urandom;
      #2 reset = 1'b1;
      #1 check_reset_values("async_reset");
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      cur_sum = '0;
      cur_len = 0;
      acc_hist[cyc]   = 1'b0;
      acc_hist[cyc+1] = 1'b0;
      cyc += 2;
   endtask

   initial begin
      bit a;
      int t0;
      repeat (2) @(negedge clk);
      check_reset_values("power_on");
      reset = 1'b0;

      // Basic vector 12+30+20: result visible 10 cycles after the first issue.
      rdy_mode = 1; popped_q.delete(); first_valid_cyc = -1; t0 = cyc;
      step(1'b1, 1'b0, 32'd12, a);
      step(1'b1, 1'b0, 32'd30, a);
      step(1'b1, 1'b1, 32'd20, a);
      idle(12);
      check("basic latency", 64'(first_valid_cyc - t0), 64'd10);
      check("basic count", popped_q.size(), 1);
      if (popped_q.size() >= 1) begin
         check("basic sum", popped_q[0].data, 62);
         check("basic ovf", popped_q[0].ovf, 0);
      end

      // Two single-element vectors back-to-back.
      popped_q.delete(); first_valid_cyc = -1; t0 = cyc;
      step(1'b1, 1'b1, 32'd5, a);
      step(1'b1, 1'b1, 32'd9, a);
      idle(12);
      check("single latency", 64'(first_valid_cyc - t0), 64'd8);
      check("single count", popped_q.size(), 2);
      if (popped_q.size() >= 2) begin
         check("single first", popped_q[0].data, 5);
         check("single second", popped_q[1].data, 9);
      end

      // Backpressure: third single-element vector waits for a FIFO slot.
      rdy_mode = 0; popped_q.delete();
      step(1'b1, 1'b1, 32'd7, a); check("bp accept1", a, 1);
      step(1'b1, 1'b1, 32'd8, a); check("bp accept2", a, 1);
      repeat (10) begin
         step(1'b1, 1'b1, 32'd9, a);
         check("bp held", a, 0);
         check("bp issue_ready", issue_ready, 1'b0);
      end
      rdy_mode = 1;
      issue_until(32'd9, 1'b1);
      idle(15);
      check("bp count", popped_q.size(), 3);
      if (popped_q.size() >= 3) begin
         check("bp order0", popped_q[0].data, 7);
         check("bp order1", popped_q[1].data, 8);
         check("bp order2", popped_q[2].data, 9);
      end

      // Overflow boundary: 4 max products fit in 34 bits, 5 do not.
      popped_q.delete();
      repeat (3) issue_until(32'hFFFF_FFFF, 1'b0);
      issue_until(32'hFFFF_FFFF, 1'b1);
      repeat (4) issue_until(32'hFFFF_FFFF, 1'b0);
      issue_until(32'hFFFF_FFFF, 1'b1);
      idle(15);
      check("ovf count", popped_q.size(), 2);
      if (popped_q.size() >= 2) begin
         check("fit sum", popped_q[0].data, 64'h3_FFFF_FFFC);
         check("fit ovf", popped_q[0].ovf, 0);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
         check("ovf sum", popped_q[1].data, 64'h3_FFFF_FFFF);
`else
         check("ovf sum", popped_q[1].data, 64'hFFFF_FFFB);
`endif
         check("ovf flag", popped_q[1].ovf, 1);
      end

      // Reset mid-vector discards everything; a fresh vector afterwards sums correctly.
      popped_q.delete();
      step(1'b1, 1'b0, 32'd100, a);
      step(1'b1, 1'b0, 32'd200, a);
      step(1'b1, 1'b1, 32'd300, a);
      idle(1);
      do_reset();
      idle(15);
      check("reset no result", popped_q.size(), 0);
      step(1'b1, 1'b0, 32'd1, a);
      step(1'b1, 1'b0, 32'd2, a);
      step(1'b1, 1'b1, 32'd3, a);
      idle(12);
      check("post reset count", popped_q.size(), 1);
      if (popped_q.size() >= 1) check("post reset sum", popped_q[0].data, 6);

      // FIFO wrap with toggling out_ready.
      rdy_mode = 2; popped_q.delete();
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k <= v; k++) issue_until(PW'(10 * v + k), (k == v));
      end
      idle(25);
      check("wrap count", popped_q.size(), 5);
      if (popped_q.size() >= 5) begin
         check("wrap r0", popped_q[0].data, 0);
         check("wrap r1", popped_q[1].data, 21);
         check("wrap r2", popped_q[2].data, 63);
         check("wrap r3", popped_q[3].data, 126);
         check("wrap r4", popped_q[4].data, 210);
      end

      // Random traffic, mixing small and near-full-scale products to reach overflow.
      rdy_mode = 3;
      repeat (1500) begin
         logic [PW-1:0] val;
         val = ($urandom_range(0, 1) == 1) ? ($urandom | 32'hFFFF_0000) : PW'($urandom_range(0, 1000));
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), val, a);
      end
      rdy_mode = 1;
      issue_until(32'd1, 1'b1);
      idle(20);
      check("drain empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
